// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 2-flop input synchroniser, optional parity, framing/break detection.
// Build option: define UART_RX_MAJORITY_EN to take each data/parity/stop bit as a 2-of-3 majority vote.
module uart_rx_ext #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      par_mode,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [3:0]    N_LAST = 4'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n, s_last;
  logic [3:0]      n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            par_en, par_en_n, par_odd, par_odd_n;
  logic            perr, perr_n, pbit, pbit_n;
  logic [DBIT-1:0] dout_n;
  logic            parity_err_n, frame_err_n, break_det_n, done_n;
  logic            sync_q, rxs, sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= rx;
      rxs    <= sync_q;
    end
  end

  assign s_last = (state == STOP) ? S_STOP : S_BIT;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj;

  // The two earlier votes are captured just before the decision tick; the third is live rxs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maj <= 2'b11;
    end else if (s_tick) begin
      if (s == s_last - SW'(2)) maj[0] <= rxs;
      if (s == s_last - SW'(1)) maj[1] <= rxs;
    end
  end

  assign sample = (maj[0] & maj[1]) | (maj[0] & rxs) | (maj[1] & rxs);
`else
  assign sample = rxs;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      perr         <= 1'b0;
      pbit         <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      par_en       <= par_en_n;
      par_odd      <= par_odd_n;
      perr         <= perr_n;
      pbit         <= pbit_n;
      dout         <= dout_n;
      parity_err   <= parity_err_n;
      frame_err    <= frame_err_n;
      break_det    <= break_det_n;
      rx_done_tick <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    s_n          = s;
    n_n          = n;
    b_n          = b;
    par_en_n     = par_en;
    par_odd_n    = par_odd;
    perr_n       = perr;
    pbit_n       = pbit;
    dout_n       = dout;
    parity_err_n = parity_err;
    frame_err_n  = frame_err;
    break_det_n  = break_det;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n   = START;
          s_n       = '0;
          par_en_n  = (par_mode == 2'b01) || (par_mode == 2'b10);
          par_odd_n = (par_mode == 2'b10);
          perr_n    = 1'b0;
          pbit_n    = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_HALF) begin
            if (!rxs) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_n = '0;
            b_n = {sample, b[DBIT-1:1]};
            if (n == N_LAST) state_n = par_en ? PARITY : STOP;
            else             n_n = n + 4'd1;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            perr_n  = sample ^ (^b) ^ par_odd;
            pbit_n  = sample;
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            dout_n       = b;
            parity_err_n = perr;
            frame_err_n  = ~sample;
            break_det_n  = (b == '0) && !pbit && !sample;
            done_n       = 1'b1;
            // A low stop bit parks in WAIT so a held-low line yields one frame, not a stream.
            state_n      = sample ? IDLE : WAIT;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      WAIT: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx_ext;

  localparam int DBIT    = 8;
  localparam int OVS     = 16;
  localparam int SB_TICK = 16;

  logic            clk;
  logic            reset;
  logic            rx;
  logic            s_tick;
  logic [1:0]      par_mode;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            parity_err;
  logic            frame_err;
  logic            break_det;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  uart_rx_ext #(.DBIT(DBIT), .OVS(OVS), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .par_mode     (par_mode),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversampling strobe: one clk high out of every four, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) pulse_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    #1;
  endtask

  // One frame on the line; glitch_bit >= 0 inverts that data bit for the single tick at its centre.
  task automatic send_frame(input logic [DBIT-1:0] data, input logic has_par, input logic pbit,
                            input logic stop_val, input int stop_ticks, input int glitch_bit);
    logic [1:0] keep_mode;
    keep_mode = par_mode;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(OVS / 2);
    par_mode = 2'($urandom);
    wait_ticks(OVS / 2);
    for (int i = 0; i < DBIT; i++) begin
      rx = data[i];
      if (i == glitch_bit) begin
        wait_ticks(OVS / 2 - 1);
        rx = ~data[i];
        wait_ticks(1);
        rx = data[i];
        wait_ticks(OVS / 2);
      end else begin
        wait_ticks(OVS);
      end
    end
    if (has_par) begin
      rx = pbit;
      wait_ticks(OVS);
    end
    rx = stop_val;
    wait_ticks(stop_ticks);
    rx = 1'b1;
    par_mode = keep_mode;
  endtask

  // Frame-level reference: what the receiver must report for a given line frame.
  task automatic model_frame(input logic [DBIT-1:0] data, input logic [1:0] mode, input logic pbit,
                             input logic stop_val, output logic perr, output logic ferr, output logic brk);
    logic has_par;
    logic want;
    has_par = (mode == 2'b01) || (mode == 2'b10);
    want    = (^data) ^ (mode == 2'b10);
    perr    = has_par && (pbit != want);
    ferr    = !stop_val;
    brk     = (data == '0) && (!has_par || !pbit) && !stop_val;
  endtask

  task automatic check_frame(input string tag, input int base, input logic [DBIT-1:0] exp_dout,
                             input logic exp_perr, input logic exp_ferr, input logic exp_brk);
    check_output({tag, ".pulses"}, 32'(pulse_cnt - base), 32'd1);
    check_output({tag, ".dout"}, 32'(dout), 32'(exp_dout));
    check_output({tag, ".parity_err"}, 32'(parity_err), 32'(exp_perr));
    check_output({tag, ".frame_err"}, 32'(frame_err), 32'(exp_ferr));
    check_output({tag, ".break_det"}, 32'(break_det), 32'(exp_brk));
  endtask

  initial begin
    int base;
    logic [DBIT-1:0] d;
    logic [1:0] m;
    logic hp, pb, st, ep, ef, eb;
    int stl;

    rx = 1'b1;
    par_mode = 2'b00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset.done", 32'(rx_done_tick), 32'd0);
    check_output("reset.dout", 32'(dout), 32'd0);
    check_output("reset.parity_err", 32'(parity_err), 32'd0);
    check_output("reset.frame_err", 32'(frame_err), 32'd0);
    check_output("reset.break_det", 32'(break_det), 32'd0);
    reset = 1'b0;
    wait_ticks(2 * OVS);

    $display("[TB] 8N1 0xA5");
    par_mode = 2'b00; base = pulse_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, SB_TICK, -1);
    wait_ticks(2 * OVS);
    check_frame("8n1_a5", base, 8'hA5, 1'b0, 1'b0, 1'b0);

    $display("[TB] 8E1 0x07 good and bad parity");
    par_mode = 2'b01; base = pulse_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, SB_TICK, -1);
    wait_ticks(2 * OVS);
    check_frame("8e1_good", base, 8'h07, 1'b0, 1'b0, 1'b0);
    base = pulse_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, SB_TICK, -1);
    wait_ticks(2 * OVS);
    check_frame("8e1_bad", base, 8'h07, 1'b1, 1'b0, 1'b0);

    $display("[TB] 8O1 0x00, then 0x55 with long low stop");
    par_mode = 2'b10; base = pulse_cnt;
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, SB_TICK, -1);
    wait_ticks(2 * OVS);
    check_frame("8o1_00", base, 8'h00, 1'b0, 1'b0, 1'b0);
    base = pulse_cnt;
    send_frame(8'h55, 1'b1, 1'b1, 1'b0, 2 * OVS, -1);
    wait_ticks(12 * OVS);
    check_frame("8o1_55_frame", base, 8'h55, 1'b0, 1'b1, 1'b0);

    $display("[TB] break of 12 bit times");
    par_mode = 2'b00; base = pulse_cnt;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(12 * OVS);
    rx = 1'b1;
    wait_ticks(12 * OVS);
    check_frame("break", base, 8'h00, 1'b0, 1'b1, 1'b1);
    base = pulse_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, SB_TICK, -1);
    wait_ticks(2 * OVS);
    check_frame("after_break_3c", base, 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("[TB] start glitch");
    base = pulse_cnt;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(3 * OVS);
    check_output("glitch.pulses", 32'(pulse_cnt - base), 32'd0);
    check_output("glitch.dout", 32'(dout), 32'h3C);

    $display("[TB] reset during data bit 3");
    base = pulse_cnt;
    d = 8'h5A;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(OVS);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      wait_ticks(OVS);
    end
    rx = d[3];
    wait_ticks(OVS / 2);
    reset = 1'b1;
    #2;
    check_output("midreset.done", 32'(rx_done_tick), 32'd0);
    check_output("midreset.dout", 32'(dout), 32'd0);
    check_output("midreset.parity_err", 32'(parity_err), 32'd0);
    check_output("midreset.frame_err", 32'(frame_err), 32'd0);
    check_output("midreset.break_det", 32'(break_det), 32'd0);
    rx = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ticks(2 * OVS);
    check_output("midreset.pulses", 32'(pulse_cnt - base), 32'd0);
    base = pulse_cnt;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, SB_TICK, -1);
    wait_ticks(2 * OVS);
    check_frame("after_reset_c3", base, 8'hC3, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
    $display("[TB] majority vote rejects centre glitch");
    par_mode = 2'b00; base = pulse_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, SB_TICK, 2);
    wait_ticks(2 * OVS);
    check_frame("majority_ff", base, 8'hFF, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] random frames");
    for (int k = 0; k < 16; k++) begin
      d  = DBIT'($urandom);
      if ($urandom_range(0, 5) == 0) d = '0;
      m  = 2'($urandom_range(0, 3));
      hp = (m == 2'b01) || (m == 2'b10);
      pb = ((^d) ^ (m == 2'b10)) ^ ($urandom_range(0, 2) == 0);
      if (d == '0 && $urandom_range(0, 1) == 0) pb = 1'b0;
      st = ($urandom_range(0, 3) != 0);
      stl = st ? SB_TICK : SB_TICK + int'($urandom_range(0, 32));
      model_frame(d, m, pb, st, ep, ef, eb);
      par_mode = m;
      base = pulse_cnt;
      send_frame(d, hp, pb, st, stl, -1);
      wait_ticks(2 * OVS);
      check_frame($sformatf("rand%0d", k), base, d, ep, ef, eb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver, the successor to the fixed 8-bit receiver. It adds configurable data width and oversampling, runtime-selectable parity (none/even/odd), and an input synchroniser. It also reports framing errors, parity errors and line breaks. It sits between the baud-rate generator (`s_tick`) and the RX FIFO, and writes one word per `rx_done_tick`.

## Interface
- `DBIT`, 8: data bits per frame, legal 5..9.
- `OVS`, 16: `s_tick` pulses per bit time; even, ≥8.
- `SB_TICK`, 16: ticks counted in stop state (16/24/32 for 1/1.5/2 stop bits at `OVS`=16).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `s_tick`  in  1  one-`clk`-wide oversampling strobe.
- `par_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `rx_done_tick`  out  1  one-cycle pulse: frame complete, outputs below valid.
- `dout`  out  `DBIT`  received word, LSB first on the line.
- `parity_err`  out  1  parity mismatch on last frame; 0 when parity is off.
- `frame_err`  out  1  stop bit sampled low on last frame.
- `break_det`  out  1  last frame was a break.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1). All logic below uses the synchronised value `rxs`.
- States: IDLE, START, DATA, PARITY, STOP, WAIT.
- IDLE: when `rxs`=0, go to START and set s=0.
- `par_mode` is latched on IDLE→START. Changes mid-frame are ignored.
- START: on each tick, s++. At s=`OVS`/2−1 (mid start bit):
  - If `rxs`=0, go to DATA with s=0 and n=0.
  - Else the start was a glitch; return to IDLE with no pulse and outputs unchanged.
- DATA: on each tick, s++. At s=`OVS`−1, sample the bit and shift `b`={bit, b[`DBIT`−1:1]}, then set s=0.
  - After `DBIT` bits, go to PARITY if parity is enabled, else to STOP.
- PARITY: sample at s=`OVS`−1.
  - Expected bit = XOR of the `DBIT` data bits for even, its inverse for odd.
  - Store the mismatch flag, then go to STOP with s=0.
- STOP: sample at s=`SB_TICK`−1. In that same cycle, update the registered outputs:
  - `dout` = `b`.
  - `parity_err` = stored mismatch.
  - `frame_err` = ~stop sample.
  - `break_det` = all data bits 0, parity bit 0 (if present), and stop sample 0.
  - Pulse `rx_done_tick`.
  - Go to IDLE if the stop sample is 1, else to WAIT.
- Every frame produces exactly one `rx_done_tick`, with or without errors.
- WAIT: stay until `rxs`=1, then go to IDLE. This prevents a break or low line from being decoded as a stream of 0x00 frames.
- Counter widths: s is wide enough for max(`OVS`, `SB_TICK`)−1; n is 4 bits.

## Timing
- Reset values:
  - `rx_done_tick`=0, `dout`=0, all error flags 0.
  - State IDLE, synchroniser flops 1.
- Start detection latency: 2 `clk` cycles from an `rx` edge to `rxs`.
- Output latency:
  - `rx_done_tick` is high for exactly one `clk` cycle, the cycle after the edge that captures the final stop tick.
  - `dout` and the error flags change on that same edge and hold until the next completed frame.
- Without `s_tick`, the FSM only moves IDLE→START and WAIT→IDLE, which are `rxs`-driven.
- Reset mid-frame: immediate return to IDLE, no `rx_done_tick`, partial word discarded.
- `DBIT`=9 with parity: 11-bit frame plus stop bits.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each data, parity and stop bit value is the 2-of-3 majority of samples taken on ticks s=`OVS`−3, `OVS`−2 and `OVS`−1 (stop: `SB_TICK`−3..−1).
- Start-bit validation is unchanged.
- Undefined: single sample at the tick listed in Operation. Timing of outputs is identical in both builds.

## Test plan
- 8N1, `par_mode`=00, send 0xA5 → one `rx_done_tick`, `dout`=0xA5, all flags 0.
- 8E1, send 0x07 with parity bit 1 → `parity_err`=0. Resend with parity bit 0 → `dout`=0x07, `parity_err`=1.
- 8O1, send 0x00 with parity bit 1 → `parity_err`=0. Then 0x55 with stop bit 0 held 2 bit times → `frame_err`=1, `break_det`=0, and no further frame until `rx` returns high.
- Hold `rx` low for 12 bit times → exactly one pulse: `dout`=0x00, `frame_err`=1, `break_det`=1. Then `rx` high, send 0x3C → clean 0x3C.
- `rx` low for 4 ticks then high → no `rx_done_tick`, FSM back in IDLE, previous `dout` retained.
- Assert `reset` during data bit 3 → all outputs 0 within the reset cycle. After release, send 0xC3 → `dout`=0xC3.
- With `UART_RX_MAJORITY_EN` defined: a single-tick glitch at s=`OVS`−1 inside data bit 2 of 0xFF → `dout`=0xFF.
